// File: rtl/core_pipe_scoreboard.sv
// -----------------------------------------------------------------------------
// core_pipe_scoreboard
//
// Hazard/forwarding scoreboard that sits beside the ID stage of the in-order
// core. It tracks the destination writes of the instructions in the DEPTH
// slots after decode. Slot 0 is EX, and slot DEPTH-1 is the last slot before
// the regfile write. For each source operand it picks a forwarding source. It
// also raises a load-use stall when load data is not yet available.
//
// Parameters
//   AW        register address width (register 0 is hardwired zero)
//   NSRC      source operands checked per issued instruction
//   DEPTH     tracked slots after ID (2..8)
//   LOAD_LAT  first slot index whose load data can be forwarded (0..DEPTH-1)
//   CW        stall performance counter width
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_issue_valid  ID holds a valid instruction requesting issue
//   i_issue_wen    issued instruction writes a register
//   i_issue_load   issued instruction is a load
//   i_issue_dst    issued destination register
//   i_src_en       per-operand read enable
//   i_src_addr     per-operand address, operand n at [n*AW +: AW]
//   i_freeze       all slots hold, nothing issues
//   i_flush        ID instruction is killed (taken branch in EX)
//   o_stall        load-use stall: hold ID, bubble into slot 0
//   o_issue        instruction enters slot 0 at this edge
//   o_fwd_sel      per operand: 0 = regfile, k+1 = forward from slot k
//   o_retire_wen   slot DEPTH-1 writes the regfile this cycle
//   o_retire_dst   slot DEPTH-1 destination
//   o_stall_cnt    saturating count of stalled (unfrozen) cycles
// -----------------------------------------------------------------------------
module core_pipe_scoreboard #(
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CW       = 32,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_issue_valid,
    input  logic                 i_issue_wen,
    input  logic                 i_issue_load,
    input  logic [AW-1:0]        i_issue_dst,
    input  logic [NSRC-1:0]      i_src_en,
    input  logic [NSRC*AW-1:0]   i_src_addr,
    input  logic                 i_freeze,
    input  logic                 i_flush,
    output logic                 o_stall,
    output logic                 o_issue,
    output logic [NSRC*FW-1:0]   o_fwd_sel,
    output logic                 o_retire_wen,
    output logic [AW-1:0]        o_retire_dst,
    output logic [CW-1:0]        o_stall_cnt
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] wen_q,   wen_d;
    logic [DEPTH-1:0] load_q,  load_d;
    logic [AW-1:0]    dst_q [DEPTH];
    logic [AW-1:0]    dst_d [DEPTH];
    logic [CW-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NSRC-1:0]    hazard;
    logic [NSRC*FW-1:0] fwd_sel;
    logic               found;
    logic [AW-1:0]      src;

    // The scan runs from the youngest slot (0) to the oldest. The first match
    // decides the result. Older writes to the same register are stale.
    always_comb begin
        hazard  = '0;
        fwd_sel = '0;
        found   = 1'b0;
        src     = '0;
        for (int n = 0; n < NSRC; n++) begin
            found = 1'b0;
            src   = i_src_addr[n*AW +: AW];
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && i_src_en[n] && valid_q[k] && wen_q[k] &&
                    (dst_q[k] == src) && (src != '0)) begin
                    found = 1'b1;
                    if (load_q[k] && (k < LOAD_LAT)) begin
                        hazard[n] = 1'b1;
                    end else begin
                        fwd_sel[n*FW +: FW] = FW'(k + 1);
                    end
                end
            end
        end
    end

    assign o_fwd_sel = fwd_sel;
    assign o_stall   = i_issue_valid & (|hazard) & ~i_flush;
    // o_issue depends only on inputs and o_stall. Gating it with rst_n keeps
    // it low while reset is held, even when the inputs are active.
    assign o_issue   = rst_n & i_issue_valid & ~o_stall & ~i_flush & ~i_freeze;

    assign o_retire_wen = valid_q[DEPTH-1] & wen_q[DEPTH-1];
    assign o_retire_dst = dst_q[DEPTH-1];
    assign o_stall_cnt  = stall_cnt_q;

    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        load_d  = load_q;
        for (int k = 0; k < DEPTH; k++) begin
            dst_d[k] = dst_q[k];
        end
        if (!i_freeze) begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                wen_d[k]   = wen_q[k-1];
                load_d[k]  = load_q[k-1];
                dst_d[k]   = dst_q[k-1];
            end
            if (o_issue) begin
                valid_d[0] = 1'b1;
                // A write to x0 is never visible, so it is stored as a non-write.
                wen_d[0]   = i_issue_wen & (i_issue_dst != '0);
                load_d[0]  = i_issue_load;
                dst_d[0]   = i_issue_dst;
            end else begin
                valid_d[0] = 1'b0;
                wen_d[0]   = 1'b0;
                load_d[0]  = 1'b0;
                dst_d[0]   = '0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && !i_freeze && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            wen_q       <= '0;
            load_q      <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            wen_q       <= wen_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                dst_q[k] <= dst_d[k];
            end
        end
    end

endmodule

// File: tb/tb_core_pipe_scoreboard.sv
module tb_core_pipe_scoreboard;

    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int FW   = 2;
    localparam int CW   = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 i_issue_valid;
    logic                 i_issue_wen;
    logic                 i_issue_load;
    logic [AW-1:0]        i_issue_dst;
    logic [NSRC-1:0]      i_src_en;
    logic [NSRC*AW-1:0]   i_src_addr;
    logic                 i_freeze;
    logic                 i_flush;
    logic                 o_stall;
    logic                 o_issue;
    logic [NSRC*FW-1:0]   o_fwd_sel;
    logic                 o_retire_wen;
    logic [AW-1:0]        o_retire_dst;
    logic [CW-1:0]        o_stall_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_cnt = 0;

    core_pipe_scoreboard #(.AW(AW), .NSRC(NSRC), .DEPTH(3), .LOAD_LAT(2), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_wen   (i_issue_wen),
        .i_issue_load  (i_issue_load),
        .i_issue_dst   (i_issue_dst),
        .i_src_en      (i_src_en),
        .i_src_addr    (i_src_addr),
        .i_freeze      (i_freeze),
        .i_flush       (i_flush),
        .o_stall       (o_stall),
        .o_issue       (o_issue),
        .o_fwd_sel     (o_fwd_sel),
        .o_retire_wen  (o_retire_wen),
        .o_retire_dst  (o_retire_dst),
        .o_stall_cnt   (o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge. Checks run 1 time unit
    // later, which is well clear of the next rising edge.
    task automatic drive(input logic v, input logic w, input logic ld, input logic [AW-1:0] d,
                         input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic frz, input logic fl);
        @(negedge clk);
        i_issue_valid = v;
        i_issue_wen   = w;
        i_issue_load  = ld;
        i_issue_dst   = d;
        i_src_en      = en;
        i_src_addr    = {a1, a0};
        i_freeze      = frz;
        i_flush       = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_issue_valid = 1'($urandom);
            i_issue_wen   = 1'($urandom);
            i_issue_load  = 1'($urandom);
            i_issue_dst   = AW'($urandom);
            i_src_en      = NSRC'($urandom);
            i_src_addr    = (NSRC*AW)'($urandom);
            i_freeze      = 1'($urandom);
            i_flush       = 1'($urandom);
            #1;
            n_total++;
            if ({o_stall, o_issue, o_fwd_sel, o_retire_wen, o_retire_dst} !== '0 || o_stall_cnt !== '0)
                $display("FAIL reset_outputs: got stall=%0b issue=%0b fwd=%0h rwen=%0b rdst=%0d cnt=%0d, want all 0",
                         o_stall, o_issue, o_fwd_sel, o_retire_wen, o_retire_dst, o_stall_cnt);
            else n_pass++;
        end
        idle(1);
        rst_n = 1'b1;
        drive(1, 1, 0, 5, 2'b00, 0, 0, 0, 0);
        n_total++;
        if (o_issue !== 1'b1) $display("FAIL reset_first_issue: got %0b want 1", o_issue);
        else n_pass++;
    endtask

    task automatic test_alu_chain();
        logic [FW-1:0] exp_f [4];
        exp_f[0] = 1; exp_f[1] = 2; exp_f[2] = 3; exp_f[3] = 0;
        idle(4);
        drive(1, 1, 0, 5, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 2'b01, 5, 0, 0, 0);
            n_total++;
            if (o_fwd_sel[FW-1:0] !== exp_f[i])
                $display("FAIL alu_chain_fwd%0d: got %0d want %0d", i, o_fwd_sel[FW-1:0], exp_f[i]);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (o_retire_wen !== 1'b1 || o_retire_dst !== 5)
                    $display("FAIL alu_chain_retire: got wen=%0b dst=%0d want 1/5", o_retire_wen, o_retire_dst);
                else n_pass++;
            end
        end
    endtask

    task automatic test_load_use();
        idle(4);
        drive(1, 1, 1, 7, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 2'b10, 0, 7, 0, 0);
            n_total++;
            if (o_stall !== 1'b1 || o_issue !== 1'b0)
                $display("FAIL load_use_stall%0d: got stall=%0b issue=%0b want 1/0", i, o_stall, o_issue);
            else n_pass++;
            exp_cnt++;
        end
        drive(1, 0, 0, 0, 2'b10, 0, 7, 0, 0);
        n_total++;
        if (o_stall !== 1'b0 || o_issue !== 1'b1 || o_fwd_sel[2*FW-1:FW] !== 3)
            $display("FAIL load_use_fwd: got stall=%0b issue=%0b fwd1=%0d want 0/1/3",
                     o_stall, o_issue, o_fwd_sel[2*FW-1:FW]);
        else n_pass++;
        n_total++;
        if (o_stall_cnt !== exp_cnt) $display("FAIL load_use_cnt: got %0d want %0d", o_stall_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_x0_priority();
        idle(4);
        drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
        n_total++;
        if (o_fwd_sel !== '0) $display("FAIL x0_fwd: got %0h want 0", o_fwd_sel);
        else n_pass++;
        idle(4);
        drive(1, 1, 0, 9, 2'b00, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 2'b00, 0, 0, 0, 0);
        drive(1, 1, 0, 9, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b11, 9, 3, 0, 0);
        n_total++;
        if (o_fwd_sel[FW-1:0] !== 1) $display("FAIL priority_youngest: got %0d want 1", o_fwd_sel[FW-1:0]);
        else n_pass++;
        n_total++;
        if (o_fwd_sel[2*FW-1:FW] !== 2) $display("FAIL priority_mid: got %0d want 2", o_fwd_sel[2*FW-1:FW]);
        else n_pass++;
    endtask

    task automatic test_freeze();
        idle(4);
        drive(1, 1, 1, 7, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 2'b01, 7, 0, 1, 0);
            n_total++;
            if (o_stall !== 1'b1 || o_issue !== 1'b0)
                $display("FAIL freeze_stall%0d: got stall=%0b issue=%0b want 1/0", i, o_stall, o_issue);
            else n_pass++;
        end
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        n_total++;
        if (o_stall_cnt !== exp_cnt) $display("FAIL freeze_cnt_hold: got %0d want %0d", o_stall_cnt, exp_cnt);
        else n_pass++;
        n_total++;
        if (o_stall !== 1'b1) $display("FAIL freeze_slot_held: got stall=%0b want 1", o_stall);
        else n_pass++;
        exp_cnt++;
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        exp_cnt++;
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        n_total++;
        if (o_stall !== 1'b0 || o_fwd_sel[FW-1:0] !== 3 || o_stall_cnt !== exp_cnt)
            $display("FAIL freeze_release: got stall=%0b fwd0=%0d cnt=%0d want 0/3/%0d",
                     o_stall, o_fwd_sel[FW-1:0], o_stall_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        idle(4);
        drive(1, 1, 1, 7, 2'b00, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 1);
        n_total++;
        if (o_stall !== 1'b0 || o_issue !== 1'b0)
            $display("FAIL flush_kill: got stall=%0b issue=%0b want 0/0", o_stall, o_issue);
        else n_pass++;
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        n_total++;
        if (o_stall !== 1'b1 || o_fwd_sel[FW-1:0] !== 0)
            $display("FAIL flush_bubble: got stall=%0b fwd0=%0d want 1/0", o_stall, o_fwd_sel[FW-1:0]);
        else n_pass++;
        exp_cnt++;
        drive(1, 0, 0, 0, 2'b01, 7, 0, 0, 0);
        n_total++;
        if (o_fwd_sel[FW-1:0] !== 3 || o_stall_cnt !== exp_cnt)
            $display("FAIL flush_after: got fwd0=%0d cnt=%0d want 3/%0d", o_fwd_sel[FW-1:0], o_stall_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        idle(4);
        drive(1, 1, 0, 6, 2'b00, 0, 0, 0, 0);
        drive(1, 1, 0, 6, 2'b00, 0, 0, 0, 0);
        drive(1, 1, 0, 6, 2'b00, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b01, 6, 0, 0, 0);
        n_total++;
        if (o_retire_wen !== 1'b1 || o_fwd_sel[FW-1:0] !== 1)
            $display("FAIL async_pre: got rwen=%0b fwd0=%0d want 1/1", o_retire_wen, o_fwd_sel[FW-1:0]);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (o_retire_wen !== 1'b0 || o_retire_dst !== 0 || o_fwd_sel !== '0 || o_stall_cnt !== 0)
            $display("FAIL async_clear: got rwen=%0b rdst=%0d fwd=%0h cnt=%0d want all 0",
                     o_retire_wen, o_retire_dst, o_fwd_sel, o_stall_cnt);
        else n_pass++;
        idle(1);
        rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0;
        i_issue_valid = 0; i_issue_wen = 0; i_issue_load = 0; i_issue_dst = 0;
        i_src_en = 0; i_src_addr = 0; i_freeze = 0; i_flush = 0;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_x0_priority();
        test_freeze();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
